reset_controller: RTL
=====================

# reset_controller

Reset and supervision stage that sits directly upstream of `system` in the f8 test and FPGA top levels. It converts the raw `power_on_reset` into a stretched `system_reset` that drives `system`. It consumes `system`'s `trap` output and a watchdog kick, turning either event into a controlled re-reset. It also records the cause and counts traps, so benches and boards can report failures instead of just stopping.

## Interface
Parameters:
- `STRETCH_CYCLES`, 16: number of cycles `system_reset` is held after any reset source deasserts or fires; legal range 1..255.
- `WDT_WIDTH`, 16: watchdog counter width.
- `WDT_RELOAD`, 16'hFFFF: watchdog reload value.
- `TRAP_RESET`, 1: 1 means a trap causes a re-reset; 0 means traps are only counted.

Ports:
- `clk`  in  1  system clock; the only clock.
- `power_on_reset`  in  1  reset; synchronous, active-high; also a reset source.
- `trap`  in  1  trap output of `system`; level signal, edge-detected here.
- `wdt_enable`  in  1  watchdog runs while high.
- `wdt_kick`  in  1  one-cycle reload strobe.
- `system_reset`  out  1  reset to `system`; synchronous active-high.
- `reset_cause`  out  2  cause of the last reset: POR, TRAP or WDT.
- `trap_count`  out  8  saturating count of trap edges since power-on.
- `wdt_expired`  out  1  one-cycle pulse on watchdog expiry.

## Operation
- States: HOLD and RUN.
- HOLD:
  - `system_reset`=1.
  - The stretch counter counts down; on reaching 0 the block moves to RUN and loads the watchdog with `WDT_RELOAD`.
- RUN:
  - `system_reset`=0.
  - Watchdog: if `wdt_enable`=1 and `wdt_kick`=1, reload. Otherwise, if `wdt_enable`=1 and the counter is 0, expire. Otherwise, if `wdt_enable`=1, decrement. If `wdt_enable`=0, the counter holds.
  - Trap edge (`trap`=1 and registered `trap_q`=0) with `TRAP_RESET`=1: go to HOLD, `reset_cause`=TRAP, stretch counter loaded.
  - Watchdog expiry: go to HOLD, `reset_cause`=WDT, `wdt_expired` pulses for 1 cycle, stretch counter loaded.
- Priority in the same cycle: `power_on_reset` > trap edge > watchdog expiry. A kick in the expiry cycle prevents expiry.
- `trap_count` increments on every trap edge in RUN, in either `TRAP_RESET` mode, and saturates at 255.
- `trap_q` updates every cycle in all states. A trap still high when the block re-enters RUN is therefore not re-counted.
- Trap edges and kicks are ignored in HOLD.
- `power_on_reset`=1, from any state and mid-stretch included:
  - state HOLD, stretch counter reloaded to `STRETCH_CYCLES`;
  - `reset_cause`=POR;
  - `trap_count`=0, `trap_q`=0, watchdog counter=`WDT_RELOAD`, `wdt_expired`=0.
- Trap and watchdog re-resets do not clear `trap_count`.

## Timing
- Reset values while `power_on_reset`=1: `system_reset`=1, `reset_cause`=POR (2'd0), `trap_count`=0, `wdt_expired`=0.
- All outputs are registered.
- POR release: `system_reset` falls exactly `STRETCH_CYCLES` rising edges after the first edge at which `power_on_reset` is sampled 0.
- Trap latency: `system_reset` rises at the edge that samples the trap edge, i.e. 1 cycle. It is held for `STRETCH_CYCLES` cycles.
- Watchdog: with `wdt_enable` held high and no kicks, expiry occurs `WDT_RELOAD`+1 cycles after entering RUN. `system_reset` rises at that same edge.
- `reset_cause` changes only on the edge entering HOLD and is stable otherwise.

## Structure
- Package `f8_reset_pkg`:
  - cause enum: `CAUSE_POR`=2'd0, `CAUSE_TRAP`=2'd1, `CAUSE_WDT`=2'd2;
  - state enum: HOLD, RUN.
- One sub-module, `wdt_counter`: parameterised by width and reload; inputs `load`, `enable`, `kick`; output `expire`.
- Stretch counter, edge detector and FSM live in `reset_controller`.
- The top level instantiates `reset_controller` between the reset source and `system`.

## Test plan
All scenarios use `STRETCH_CYCLES`=16 and `WDT_RELOAD`=100.
- POR held for 2 cycles, then low -> `system_reset` falls on the 16th edge after release; `reset_cause`=0; `trap_count`=0.
- `trap` pulse 1 cycle in RUN, `TRAP_RESET`=1 -> `system_reset` high 1 edge later for 16 cycles; `reset_cause`=1; `trap_count`=1.
- `trap` held high through the entire re-reset -> `trap_count` stays 1, no second re-reset; a later low-to-high edge gives `trap_count`=2.
- `wdt_enable`=1, no kicks -> `wdt_expired` pulse and `system_reset` rise 101 cycles after entering RUN; `reset_cause`=2.
- `wdt_enable`=1, kick every 50 cycles for 1000 cycles -> no expiry. A kick in the exact expiry cycle also prevents expiry.
- Same-cycle trap edge and watchdog expiry -> `reset_cause`=1. POR asserted mid-stretch -> stretch restarts from 16, `reset_cause`=0, `trap_count`=0.

Source files
------------

// File: rtl/f8_reset_pkg.sv
// Shared types and constants for the reset/supervision stage in front of `system`.
package f8_reset_pkg;

  // Why the most recent reset happened; encoding is visible on reset_cause.
  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_TRAP = 2'd1,
    CAUSE_WDT  = 2'd2
  } cause_e;

  // HOLD keeps system_reset asserted; RUN lets `system` execute.
  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int STRETCH_W = 8;
  localparam int COUNT_W   = 8;

  // Saturating increment used for the trap counter.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wdt_counter.sv
// Down-counting watchdog: reloads on load or kick, flags expiry when it is
// enabled, already at zero and not being kicked.
module wdt_counter #(
  parameter int                 WIDTH  = 16,
  parameter logic [WIDTH-1:0]   RELOAD = '1
) (
  input  logic clk,
  input  logic load,
  input  logic enable,
  input  logic kick,
  output logic expire
);

  logic [WIDTH-1:0] cnt;

  // A kick in the zero cycle wins over expiry.
  assign expire = enable && !kick && (cnt == '0);

  // Counter: load has priority, then kick reload, then decrement; holds when disabled.
  always_ff @(posedge clk) begin
    if (load) begin
      cnt <= RELOAD;
    end else if (enable) begin
      if (kick || cnt == '0) cnt <= RELOAD;
      else                   cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/reset_controller.sv
// Stretches power-on reset into system_reset, and turns trap edges and
// watchdog expiry into controlled re-resets while recording the cause.
module reset_controller
  import f8_reset_pkg::*;
#(
  parameter int                     STRETCH_CYCLES = 16,
  parameter int                     WDT_WIDTH      = 16,
  parameter logic [WDT_WIDTH-1:0]   WDT_RELOAD     = 16'hFFFF,
  parameter int                     TRAP_RESET     = 1
) (
  input  logic                clk,
  input  logic                power_on_reset,
  input  logic                trap,
  input  logic                wdt_enable,
  input  logic                wdt_kick,
  output logic                system_reset,
  output logic [1:0]          reset_cause,
  output logic [COUNT_W-1:0]  trap_count,
  output logic                wdt_expired
);

  localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(STRETCH_CYCLES);

  state_e               state, state_n;
  cause_e               cause, cause_n;
  logic [STRETCH_W-1:0] stretch, stretch_n;
  logic [COUNT_W-1:0]   count, count_n;
  logic                 expired_n;
  logic                 trap_q;
  logic                 sys_rst;
  logic                 trap_edge;
  logic                 hold_done;
  logic                 wdt_load;
  logic                 wdt_run;
  logic                 wdt_expire;

  // Last stretch cycle: the next edge enters RUN.
  assign hold_done = (state == HOLD) && (stretch <= 8'd1);
  assign trap_edge = (state == RUN) && trap && !trap_q;
  assign wdt_load  = power_on_reset || hold_done;
  assign wdt_run   = wdt_enable && (state == RUN);

  wdt_counter #(
    .WIDTH  (WDT_WIDTH),
    .RELOAD (WDT_RELOAD)
  ) u_wdt (
    .clk    (clk),
    .load   (wdt_load),
    .enable (wdt_run),
    .kick   (wdt_kick),
    .expire (wdt_expire)
  );

  // Next-state logic: stretch countdown in HOLD, trap/watchdog supervision in RUN.
  always_comb begin
    state_n   = state;
    cause_n   = cause;
    stretch_n = stretch;
    count_n   = count;
    expired_n = 1'b0;
    case (state)
      HOLD: begin
        if (hold_done) begin
          state_n   = RUN;
          stretch_n = '0;
        end else begin
          stretch_n = stretch - 1'b1;
        end
      end
      RUN: begin
        if (trap_edge) count_n = sat_inc(count);
        // A trap re-reset outranks a same-cycle expiry, which is then not reported.
        if (trap_edge && TRAP_RESET != 0) begin
          state_n   = HOLD;
          stretch_n = STRETCH_LOAD;
          cause_n   = CAUSE_TRAP;
        end else if (wdt_expire) begin
          state_n   = HOLD;
          stretch_n = STRETCH_LOAD;
          cause_n   = CAUSE_WDT;
          expired_n = 1'b1;
        end
      end
      default: state_n = HOLD;
    endcase
  end

  // State and output registers; power_on_reset overrides everything synchronously.
  always_ff @(posedge clk) begin
    if (power_on_reset) begin
      state   <= HOLD;
      stretch <= STRETCH_LOAD;
      cause   <= CAUSE_POR;
      count   <= '0;
      wdt_expired <= 1'b0;
      trap_q  <= 1'b0;
      sys_rst <= 1'b1;
    end else begin
      state   <= state_n;
      stretch <= stretch_n;
      cause   <= cause_n;
      count   <= count_n;
      wdt_expired <= expired_n;
      trap_q  <= trap;
      sys_rst <= (state_n == HOLD);
    end
  end

  assign system_reset = sys_rst;
  assign reset_cause  = cause;
  assign trap_count   = count;

endmodule
